regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with write-to-read bypass and a per-register pending-write scoreboard.
- A hardware clear sequencer zeroes the array after reset.
- Sits in the ID stage: read ports feed operand fetch, two write ports take WB/LSU results, scoreboard drives load-use stall logic.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers, power of two, >= 4; entry 0 is hardwired zero.
- NUM_RD, 2, number of read ports, 1..4.
- AW, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- init_done  out  1  high once the clear sequence has finished.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  read data, combinational; port i occupies bits [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  per-port "operand pending" flag, combinational.
- wr_en  in  2  write enables; port 0 = WB, port 1 = LSU.
- wr_addr  in  2*AW  write addresses.
- wr_data  in  2*DATA_W  write data.
- sb_set  in  1  mark a destination as pending, issued at dispatch.
- sb_addr  in  AW  destination address for sb_set.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state<=INIT, clr_ptr<=1, busy[all]<=0, init_done<=0.
  - Reset asserted mid-INIT or mid-RUN restarts the clear sequence from entry 1.
- State INIT:
  - Each cycle writes regs[clr_ptr]<=0 and increments clr_ptr.
  - On the cycle clr_ptr==DEPTH-1 the entry is cleared and state<=RUN.
  - init_done<=1 on that same edge. First cycle with init_done=1 is DEPTH-1 cycles after rst deasserts.
  - wr_en and sb_set are ignored; busy stays 0.
  - All rd_data=0 and rd_busy=0.
- State RUN: normal operation. Leaves only via rst.
- Write (RUN only):
  - wr_en[k]=1 and wr_addr[k]!=0 writes regs[wr_addr[k]]<=wr_data[k] at the edge.
  - Both ports enabled to the same nonzero address: port 1 wins; port 0 data is discarded.
  - Writes to address 0 are dropped.
- Read port i (combinational, priority top to bottom):
  - state==INIT -> 0.
  - rd_en[i]=0 -> 0.
  - rd_addr[i]==0 -> 0.
  - wr_en[1] and wr_addr[1]==rd_addr[i] -> wr_data[1].
  - wr_en[0] and wr_addr[0]==rd_addr[i] -> wr_data[0].
  - otherwise regs[rd_addr[i]].
- Scoreboard, RUN only; busy[] is a DEPTH-bit register and busy[0] is always 0:
  - Clear: for each wr_en[k] with nonzero address, busy[wr_addr[k]]<=0.
  - Set: sb_set with sb_addr!=0 sets busy[sb_addr]<=1, visible the next cycle.
  - Set and clear to the same address in the same cycle: set wins, since the set represents a newer producer.
  - sb_set to an already-busy entry: remains 1; no error, no counting.
- rd_busy[i]:
  - = rd_en[i] & (state==RUN) & busy[rd_addr[i]].
  - Masked to 0 when any wr_en[k] matches rd_addr[i] in the same cycle, because the value is bypassed.
  - rd_busy[i]=0 for address 0.
- Reset values:
  - init_done=0.
  - rd_data=0 and rd_busy=0 throughout INIT.
  - Register contents are undefined only until the clear sequence reaches each entry.
- No stall or backpressure outputs beyond rd_busy; the consumer is responsible for holding the instruction.

Test Plan:
- Reset, DEPTH=32: pulse rst 1 cycle -> init_done rises exactly 31 cycles after rst low. Then reading every address returns 0.
- Write then read: write r5=0xDEADBEEF via port 0, read r5 on port 1 in the same cycle -> 0xDEADBEEF (bypass). Next cycle with wr_en=0 -> 0xDEADBEEF from the array.
- Write collision: both ports write r7 (port 0 0x11111111, port 1 0x22222222) -> same-cycle read = 0x22222222, later read = 0x22222222. Writing r0=0xFFFFFFFF -> r0 reads 0.
- Scoreboard: sb_set r9 -> next cycle rd_busy=1 for r9. Port 1 writes r9=0x55 -> rd_busy=0 that cycle and rd_data=0x55, and busy is clear afterwards. Simultaneous sb_set r9 + write r9 -> busy remains 1.
- Reset mid-operation: write r3=0xABCD, sb_set r4, assert rst in RUN -> init_done=0, rd_busy=0. After re-init, r3 reads 0 and r4 is not busy. A write issued during INIT is ignored.
- NUM_RD=4, DEPTH=64, DATA_W=64: 4 ports read r1, r2, r0 and r63 after writes of 1, 2 and 0x8000000000000000 to r1, r2 and r63 -> outputs 1, 2, 0, 0x8000000000000000; init takes 63 cycles.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write bypass, pending-write scoreboard and post-reset clear
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [1:0]               wr_en,
  input  logic [2*AW-1:0]          wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr
);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  logic [0:0]        state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic              init_done_q, init_done_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              run, last;
  logic [1:0]        wr_ok;
  assign run       = state_q == S_RUN;
  assign wr_ok     = {2{run}} & wr_en & {|wr_addr[AW +: AW], |wr_addr[0 +: AW]};
  assign init_done = init_done_q;
  // clear sequencer: walk entries 1..DEPTH-1 once, then enter RUN
  always_comb begin
    last        = !run && clr_ptr_q == AW'(DEPTH - 1);
    clr_ptr_d   = run ? clr_ptr_q : clr_ptr_q + 1'b1;
    state_d     = last ? S_RUN : state_q;
    init_done_d = init_done_q | last;
  end
  // array update: clearing during INIT, port 1 overrides port 0 on same address
  always_comb begin
    regs_d = regs_q;
    if (!run) regs_d[clr_ptr_q] = '0;
    for (int k = 0; k < 2; k++)
      if (wr_ok[k]) regs_d[wr_addr[k*AW +: AW]] = wr_data[k*DATA_W +: DATA_W];
    regs_d[0] = '0;
  end
  // scoreboard: writes retire pending entries, a dispatch set is newer and wins
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < 2; k++)
      if (wr_ok[k]) busy_d[wr_addr[k*AW +: AW]] = 1'b0;
    if (run && sb_set) busy_d[sb_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // read ports: bypass in-flight writes, hide pending flag when bypassed
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          act, hit0, hit1;
    assign a    = rd_addr[i*AW +: AW];
    assign act  = run & rd_en[i] & (a != '0);
    assign hit1 = wr_en[1] & (wr_addr[AW +: AW] == a);
    assign hit0 = wr_en[0] & (wr_addr[0 +: AW] == a);
    assign rd_data[i*DATA_W +: DATA_W] = !act ? '0 :
                                         hit1 ? wr_data[DATA_W +: DATA_W] :
                                         hit0 ? wr_data[0 +: DATA_W] : regs_q[a];
    assign rd_busy[i] = act & busy_q[a] & ~hit0 & ~hit1;
  end
  // control state with synchronous reset restarting the clear sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      clr_ptr_q   <= AW'(1);
      busy_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end
  // storage array has no reset; the sequencer clears it
  always_ff @(posedge clk) begin
    if (!rst) regs_q <= regs_d;
  end
endmodule
